// File: rtl/cache_stats_dump_sequencer.sv
// Walks the performance-counter select codes, captures each returned word and streams it to the host.
// Counting stays frozen for the whole walk so multi-word counters read back coherently.
module cache_stats_dump_sequencer #(
    parameter logic [31:0] CODE_MASK   = 32'h000F_BFFF,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        run_enable_i,
    output logic [31:0] comm_o,
    output logic [1:0]  select_o,
    input  logic [31:0] comm_i,
    output logic [31:0] word_o,
    output logic [4:0]  code_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FREEZE  = 3'd1,
        S_ADDR    = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_PUSH    = 3'd5,
        S_RESTORE = 3'd6
    } state_t;

    // Only codes 0..19 exist in the bank; higher mask bits are dropped.
    localparam logic [31:0] EFF_MASK  = CODE_MASK & 32'h000F_FFFF;
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYCLES - 1);
    localparam bit          SKIP_WAIT = (WAIT_CYCLES <= 1);

    // Returns {found, code}: lowest enabled code at or above lo; lo = 32 means none left.
    function automatic logic [5:0] find_code(input logic [31:0] mask, input logic [5:0] lo);
        logic [5:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && (6'(i) >= lo)) r = {1'b1, 5'(i)};
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [4:0] ptr_q;
    logic [2:0] wait_q;
    logic       aborted_q;
    logic [5:0] first_hit, next_hit;
    logic       abort_hit;

    assign first_hit = find_code(EFF_MASK, 6'd0);
    assign next_hit  = find_code(EFF_MASK, {1'b0, ptr_q} + 6'd1);
    assign abort_hit = abort_i && (state_q != S_IDLE) && (state_q != S_RESTORE);

    assign busy_o   = (state_q != S_IDLE);
    assign select_o = 2'b00;
    assign state_o  = state_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_FREEZE;
            S_FREEZE:  state_d = first_hit[5] ? S_ADDR : S_RESTORE;
            S_ADDR:    state_d = SKIP_WAIT ? S_CAPTURE : S_WAIT;
            S_WAIT:    if (wait_q <= 3'd1) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_PUSH;
            S_PUSH:    if (ready_i) state_d = next_hit[5] ? S_ADDR : S_RESTORE;
            S_RESTORE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_RESTORE;
    end

    // Host port: a word transfers on any rising edge with valid_o & ready_i; once raised,
    // valid_o and word_o/code_o hold until that edge, dropping early only on abort or reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            comm_o    <= '0;
            word_o    <= '0;
            code_o    <= '0;
            valid_o   <= 1'b0;
            done_o    <= 1'b0;
            ptr_q     <= '0;
            wait_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                // Count enable drops on the accepting edge so it is low for all of busy.
                S_IDLE:    comm_o <= {7'b0, run_enable_i & ~start_i, 24'b0};
                S_FREEZE: begin
                    ptr_q     <= first_hit[4:0];
                    aborted_q <= 1'b0;
                end
                S_ADDR: begin
                    comm_o[4:0] <= ptr_q;
                    wait_q      <= WAIT_LOAD;
                end
                S_WAIT:    wait_q <= wait_q - 3'd1;
                S_CAPTURE: begin
                    word_o  <= comm_i;
                    code_o  <= ptr_q;
                    valid_o <= 1'b1;
                end
                S_PUSH: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ptr_q   <= next_hit[4:0];
                    end
                end
                S_RESTORE: begin
                    comm_o    <= {7'b0, run_enable_i, 24'b0};
                    done_o    <= ~aborted_q & ~abort_i;
                    aborted_q <= 1'b0;
                end
                default: ;
            endcase
            if (abort_hit) begin
                valid_o   <= 1'b0;
                aborted_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_stats_dump_sequencer.sv
// Bench for cache_stats_dump_sequencer: a 1-cycle counter-bank model, random host backpressure,
// and a scoreboard whose expected words come from the enabled code list.
module tb_cache_stats_dump_sequencer;

    localparam logic [31:0] MASK = 32'h000F_BFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic run_en = 1'b0;
    logic ready = 1'b0;
    logic [31:0] bank_q = '0;

    logic [31:0] comm_o, word_o;
    logic [1:0]  select_o;
    logic [4:0]  code_o;
    logic        valid_o, busy_o, done_o;
    logic [2:0]  state_dbg;

    logic [31:0] z_comm_o, z_word_o;
    logic [1:0]  z_select_o;
    logic [4:0]  z_code_o;
    logic        z_valid_o, z_busy_o, z_done_o;
    logic [2:0]  z_state_dbg;

    logic [36:0] exp_q[$];

    int checks = 0, errors = 0;
    int words = 0, done_cnt = 0, busy_cycles = 0;
    int stable_err = 0, frz_err = 0, seen14 = 0, idle_err = 0;
    int z_busy = 0, z_done = 0, z_valid = 0;
    bit last_run_en = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Counter bank: registered return of 0x100 + select code.
    always @(posedge clk) bank_q <= 32'h100 + {27'b0, comm_o[4:0]};

    cache_stats_dump_sequencer #(.CODE_MASK(MASK), .WAIT_CYCLES(2)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort), .run_enable_i(run_en),
        .comm_o(comm_o), .select_o(select_o), .comm_i(bank_q), .word_o(word_o), .code_o(code_o),
        .valid_o(valid_o), .ready_i(ready), .busy_o(busy_o), .done_o(done_o), .state_o(state_dbg)
    );

    cache_stats_dump_sequencer #(.CODE_MASK(32'h0), .WAIT_CYCLES(2)) dut_z (
        .clock_i(clk), .reset_i(rst), .start_i(start), .abort_i(abort), .run_enable_i(run_en),
        .comm_o(z_comm_o), .select_o(z_select_o), .comm_i(bank_q), .word_o(z_word_o),
        .code_o(z_code_o), .valid_o(z_valid_o), .ready_i(ready), .busy_o(z_busy_o),
        .done_o(z_done_o), .state_o(z_state_dbg)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got still running, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic load_model(input logic [31:0] mask);
        exp_q.delete();
        for (int c = 0; c < 20; c++)
            if (mask[c]) exp_q.push_back({5'(c), 32'h100 + 32'(c)});
    endtask

    function automatic int count_below(input logic [31:0] mask, input int lim);
        int n;
        n = 0;
        for (int c = 0; c < 20; c++)
            if (mask[c] && c < lim) n++;
        return n;
    endfunction

    // ---------------- one cycle + scoreboard ----------------
    task automatic tick();
        bit hs, hold_now;
        logic [31:0] hw;
        logic [4:0]  hc;
        logic [36:0] e;
        hs       = valid_o && ready && !abort && !rst;
        hold_now = valid_o && !ready && !abort && !rst;
        hw = word_o;
        hc = code_o;
        last_run_en = run_en;
        if (hs) begin
            words++;
            if (exp_q.size() == 0) check("extra_word", 32'(code_o), 32'd99);
            else begin
                e = exp_q.pop_front();
                check("word_code", 32'(code_o), 32'(e[36:32]));
                check("word_data", word_o, e[31:0]);
            end
        end
        @(negedge clk);
        if (hold_now && (!valid_o || word_o != hw || code_o != hc)) stable_err++;
        if (busy_o) begin
            busy_cycles++;
            if (comm_o[24]) frz_err++;
            if (comm_o[4:0] == 5'd14) seen14++;
        end else if (!rst && comm_o != {7'b0, last_run_en, 24'b0}) idle_err++;
        if (done_o) begin
            done_cnt++;
            check("done_comm", comm_o, {7'b0, last_run_en, 24'b0});
            check("done_busy", 32'(busy_o), 32'd0);
        end
        z_busy  += int'(z_busy_o);
        z_done  += int'(z_done_o);
        z_valid += int'(z_valid_o);
    endtask

    // ---------------- drivers ----------------
    task automatic check_zero(input string pfx);
        check({pfx, "_comm"}, comm_o, 32'h0);
        check({pfx, "_word"}, word_o, 32'h0);
        check({pfx, "_code"}, 32'(code_o), 32'h0);
        check({pfx, "_valid"}, 32'(valid_o), 32'h0);
        check({pfx, "_busy"}, 32'(busy_o), 32'h0);
        check({pfx, "_done"}, 32'(done_o), 32'h0);
        check({pfx, "_select"}, 32'(select_o), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_state", 32'(state_dbg), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run_dump(input bit rnd, input int hold_code, input int extra_at);
        int n_exp, w0, d0, hold_left, iter;
        bit hold_done;
        load_model(MASK);
        n_exp = exp_q.size();
        w0 = words;
        d0 = done_cnt;
        hold_left = 0;
        hold_done = 1'b0;
        iter = 0;
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        while (done_cnt == d0 && iter < 3000) begin
            iter++;
            start = (iter == extra_at);
            if (rnd) run_en = 1'($urandom_range(0, 1));
            if (hold_left > 0) begin
                ready = 1'b0;
                hold_left--;
            end else if (!hold_done && valid_o && int'(code_o) == hold_code) begin
                ready = 1'b0;
                hold_left = 9;
                hold_done = 1'b1;
            end else begin
                ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
        end
        start = 1'b0;
        check("dump_done", 32'(done_cnt - d0), 32'd1);
        check("dump_words", 32'(words - w0), 32'(n_exp));
        check("dump_queue", 32'(exp_q.size()), 32'd0);
        if (hold_code >= 0) check("hold_seen", 32'(hold_done), 32'd1);
    endtask

    task automatic run_abort(input bit at_handshake, input int code);
        int w0, d0, iter;
        bit hit;
        load_model(MASK);
        w0 = words;
        d0 = done_cnt;
        iter = 0;
        hit = 1'b0;
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        while (!hit && iter < 500) begin
            iter++;
            if (at_handshake) hit = valid_o && int'(code_o) == code;
            else              hit = busy_o && !valid_o && int'(comm_o[4:0]) == code;
            if (hit) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check("abort_reached", 32'(hit), 32'd1);
        check("abort_valid", 32'(valid_o), 32'd0);
        tick();
        check("abort_comm", comm_o, {7'b0, run_en, 24'b0});
        check("abort_busy", 32'(busy_o), 32'd0);
        repeat (5) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_words", 32'(words - w0), 32'(count_below(MASK, code)));
        exp_q.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b0, iter;
        bit hit;
        run_en = 1'b1;
        do_reset();

        tick(); tick();
        check("idle_run_en", comm_o, 32'h0100_0000);
        run_en = 1'b0;
        tick();
        check("idle_run_dis", comm_o, 32'h0);
        run_en = 1'b1;
        tick();

        // Full dump at full rate; the zero-mask instance sees the same start.
        z_busy = 0; z_done = 0; z_valid = 0;
        run_dump(1'b0, -1, -1);
        check("zmask_busy_cycles", 32'(z_busy), 32'd2);
        check("zmask_done", 32'(z_done), 32'd1);
        check("zmask_valid_cycles", 32'(z_valid), 32'd0);

        // Random backpressure with a 10-cycle stall on code 3, random run_en during the dump.
        run_dump(1'b1, 3, -1);
        run_en = 1'b1;
        tick();

        run_abort(1'b0, 5);
        run_abort(1'b1, 9);

        // Second start while busy must not queue another dump.
        run_dump(1'b1, -1, 15);
        run_en = 1'b1;
        b0 = busy_cycles;
        repeat (20) tick();
        check("no_queued_start", 32'(busy_cycles - b0), 32'd0);

        // Asynchronous reset while a word is waiting in PUSH.
        load_model(MASK);
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        iter = 0;
        hit = 1'b0;
        while (!hit && iter < 500) begin
            iter++;
            hit = valid_o && code_o == 5'd7;
            if (hit) ready = 1'b0;
            tick();
        end
        tick();
        check("rst_reached", 32'(hit), 32'd1);
        check("rst_pre_valid", 32'(valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_zero("async_rst");
        do_reset();

        run_dump(1'b1, -1, -1);
        run_en = 1'b1;
        repeat (3) tick();

        check("stable_errors", 32'(stable_err), 32'd0);
        check("count_enable_while_busy", 32'(frz_err), 32'd0);
        check("code14_driven", 32'(seen14), 32'd0);
        check("idle_comm_errors", 32'(idle_err), 32'd0);
        check("zmask_comm", z_comm_o, 32'h0100_0000);
        check("zmask_word", z_word_o, 32'h0);
        check("zmask_code", 32'(z_code_o), 32'h0);
        check("zmask_select", 32'(z_select_o), 32'h0);
        check("zmask_state", 32'(z_state_dbg), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
